// File: rtl/gray_fifo_ctrl_if.sv
// rtl/gray_fifo_ctrl_if.sv - handshake and RAM-control bundle for gray_fifo_ctrl
// Purpose: groups the producer/consumer requests and the pointer/flag outputs.
// Modports: master = controller side (takes requests, drives RAM strobes,
//           addresses, Gray pointers, flags); slave = producer/consumer/RAM side.
// Optional: GRAY_FIFO_CTRL_ERR_EN adds the sticky ovf_err/udf_err signals.
interface gray_fifo_ctrl_if #(
  parameter int AW = 4
);
  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   wr_gray;
  logic [AW:0]   rd_gray;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic          ovf_err;
  logic          udf_err;
`endif

  modport master (
    input  wr_req, rd_req,
    output wr_en, wr_addr, rd_en, rd_addr, wr_gray, rd_gray, full, empty, count
`ifdef GRAY_FIFO_CTRL_ERR_EN
    , output ovf_err, udf_err
`endif
  );

  modport slave (
    output wr_req, rd_req,
    input  wr_en, wr_addr, rd_en, rd_addr, wr_gray, rd_gray, full, empty, count
`ifdef GRAY_FIFO_CTRL_ERR_EN
    , input ovf_err, udf_err
`endif
  );
endinterface

// File: rtl/gray_fifo_ctrl.sv
// rtl/gray_fifo_ctrl.sv - single-clock Gray-pointer FIFO controller for an external RAM
// Purpose: accepts push/pop requests, drives RAM write/read strobes and addresses,
//          keeps registered Gray pointers plus full/empty/count derived from them.
// Ports:   clk  - clock, all state on posedge
//          rst  - synchronous reset, active-high
//          bus  - gray_fifo_ctrl_if.master: wr_req/rd_req in; wr_en/wr_addr,
//                 rd_en/rd_addr, wr_gray/rd_gray, full/empty/count out
// Optional: GRAY_FIFO_CTRL_ERR_EN adds sticky ovf_err/udf_err on the bus.
module gray_fifo_ctrl #(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  gray_fifo_ctrl_if.master  bus
);

  logic [AW:0] wr_bin, rd_bin;
  logic [AW:0] wr_bin_nxt, rd_bin_nxt;
  logic [AW:0] wr_gray_q, rd_gray_q;
  logic [AW:0] wr_gray_nxt, rd_gray_nxt;
  logic [AW:0] count_q, count_nxt;
  logic        full_q, empty_q;
  logic        full_nxt, empty_nxt;
  logic        push_ok, pop_ok;

  always_comb begin
    // Acceptance uses only the registered flags, so a pop freeing a slot
    // cannot admit a push in the same cycle when full.
    push_ok     = bus.wr_req & ~full_q  & ~rst;
    pop_ok      = bus.rd_req & ~empty_q & ~rst;
    wr_bin_nxt  = wr_bin + {{AW{1'b0}}, push_ok};
    rd_bin_nxt  = rd_bin + {{AW{1'b0}}, pop_ok};
    wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1);
    rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1);
    empty_nxt   = (wr_gray_nxt == rd_gray_nxt);
    // Full in Gray space: top two bits inverted, the rest equal.
    full_nxt    = (wr_gray_nxt == {~rd_gray_nxt[AW:AW-1], rd_gray_nxt[AW-2:0]});
    count_nxt   = wr_bin_nxt - rd_bin_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin    <= '0;
      rd_bin    <= '0;
      wr_gray_q <= '0;
      rd_gray_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      wr_bin    <= wr_bin_nxt;
      rd_bin    <= rd_bin_nxt;
      wr_gray_q <= wr_gray_nxt;
      rd_gray_q <= rd_gray_nxt;
      count_q   <= count_nxt;
      full_q    <= full_nxt;
      empty_q   <= empty_nxt;
    end
  end

  assign bus.wr_en   = push_ok;
  assign bus.rd_en   = pop_ok;
  assign bus.wr_addr = wr_bin[AW-1:0];
  assign bus.rd_addr = rd_bin[AW-1:0];
  assign bus.wr_gray = wr_gray_q;
  assign bus.rd_gray = rd_gray_q;
  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;

`ifdef GRAY_FIFO_CTRL_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_req & full_q)  ovf_q <= 1'b1;
      if (bus.rd_req & empty_q) udf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`endif

endmodule
